// File: rtl/escalonador_rodada.sv
// escalonador_rodada: round scheduler for the two-player light-cycle arena.
// Owns the 80x60 grid RAM port, the game tick and both player positions.
module escalonador_rodada #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int BORDER     = 2,
    parameter int TICK       = 2500000,
    parameter int START_X1   = 27,
    parameter int START_X2   = 52,
    parameter int START_Y    = 30,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        reiniciar,
    input  logic [1:0]  dir1,
    input  logic [1:0]  dir2,
    input  logic        disp_req,
    input  logic [12:0] disp_addr,
    output logic        disp_grant,
    output logic        disp_valid,
    output logic [12:0] mem_addr,
    output logic [1:0]  mem_wdata,
    output logic        mem_we,
    input  logic [1:0]  mem_rdata,
    output logic [6:0]  x1,
    output logic [5:0]  y1,
    output logic [6:0]  x2,
    output logic [5:0]  y2,
    output logic [9:0]  score1,
    output logic [9:0]  score2,
    output logic        game_over,
    output logic        busy
);

    localparam int CELLS    = COLS * ROWS;
    localparam int TICK_W   = $clog2(TICK + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [3:0] {
        CLEAR, WAIT_TICK, MARK1, MARK2, CALC,
        READ1, CAP1, READ2, CAP2, JUDGE, OVER
    } state_t;

    state_t state, state_nxt;

    logic [12:0]         clr_addr;
    logic [6:0]          clr_col;
    logic [5:0]          clr_row;
    logic [STARVE_W-1:0] starve;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick_pending;
    logic [1:0]          last_dir1, last_dir2;
    logic [1:0]          eff_dir1, eff_dir2;
    logic [6:0]          nx1, nx2;
    logic [5:0]          ny1, ny2;
    logic [1:0]          d1, d2;
    logic                access, sched_go, clr_wall, tick_run;
    logic                same_cell, c1, c2;
    logic [12:0]         sched_addr;
    logic [1:0]          sched_wdata;
    logic                sched_we;

    function automatic logic [12:0] cell_addr(input logic [6:0] col, input logic [5:0] row);
        return 13'(int'(row) * COLS + int'(col));
    endfunction

    function automatic logic [1:0] pick_dir(input logic [1:0] req, input logic [1:0] last);
        return (req == (last ^ 2'd2)) ? last : req;
    endfunction

    function automatic logic [6:0] step_col(input logic [6:0] col, input logic [1:0] dir);
        logic [6:0] r;
        r = col;
        if (dir == 2'd0)
            r = col + 7'd1;
        else if (dir == 2'd2)
            r = col - 7'd1;
        return r;
    endfunction

    function automatic logic [5:0] step_row(input logic [5:0] row, input logic [1:0] dir);
        logic [5:0] r;
        r = row;
        if (dir == 2'd1)
            r = row + 6'd1;
        else if (dir == 2'd3)
            r = row - 6'd1;
        return r;
    endfunction

    function automatic logic [9:0] sat_inc(input logic [9:0] s);
        return (s == 10'd1023) ? s : s + 10'd1;
    endfunction

    // Arbitration: display wins an access cycle until it has blocked the scheduler STARVE_MAX times
    always_comb begin
        access     = (state == CLEAR) || (state == MARK1) || (state == MARK2) ||
                     (state == READ1) || (state == READ2);
        disp_grant = access ? (disp_req && (starve < STARVE_W'(STARVE_MAX))) : disp_req;
        sched_go   = access && !disp_grant;
        tick_run   = (state != CLEAR) && (state != OVER);
    end

    always_comb begin
        clr_wall  = (int'(clr_row) < BORDER) || (int'(clr_row) >= ROWS - BORDER) ||
                    (int'(clr_col) < BORDER) || (int'(clr_col) >= COLS - BORDER);
        eff_dir1  = pick_dir(dir1, last_dir1);
        eff_dir2  = pick_dir(dir2, last_dir2);
        same_cell = (nx1 == nx2) && (ny1 == ny2);
        c1        = (d1 != 2'd0) || same_cell;
        c2        = (d2 != 2'd0) || same_cell;
    end

    always_comb begin
        sched_addr  = 13'd0;
        sched_wdata = 2'd0;
        sched_we    = 1'b0;
        case (state)
            CLEAR: begin
                sched_addr  = clr_addr;
                sched_wdata = clr_wall ? 2'd3 : 2'd0;
                sched_we    = 1'b1;
            end
            MARK1: begin
                sched_addr  = cell_addr(x1, y1);
                sched_wdata = 2'd1;
                sched_we    = 1'b1;
            end
            MARK2: begin
                sched_addr  = cell_addr(x2, y2);
                sched_wdata = 2'd2;
                sched_we    = 1'b1;
            end
            READ1:   sched_addr = cell_addr(nx1, ny1);
            READ2:   sched_addr = cell_addr(nx2, ny2);
            default: sched_addr = 13'd0;
        endcase
    end

    assign mem_addr  = disp_grant ? disp_addr : sched_addr;
    assign mem_wdata = sched_wdata;
    assign mem_we    = sched_go && sched_we;
    assign busy      = (state == CLEAR);

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:     if (sched_go && (int'(clr_addr) == CELLS - 1)) state_nxt = WAIT_TICK;
            WAIT_TICK: if (tick_pending) state_nxt = MARK1;
            MARK1:     if (sched_go) state_nxt = MARK2;
            MARK2:     if (sched_go) state_nxt = CALC;
            CALC:      state_nxt = READ1;
            READ1:     if (sched_go) state_nxt = CAP1;
            CAP1:      state_nxt = READ2;
            READ2:     if (sched_go) state_nxt = CAP2;
            CAP2:      state_nxt = JUDGE;
            JUDGE:     state_nxt = (c1 || c2) ? OVER : WAIT_TICK;
            OVER:      state_nxt = OVER;
            default:   state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset || reiniciar) begin
            state        <= CLEAR;
            clr_addr     <= 13'd0;
            clr_col      <= 7'd0;
            clr_row      <= 6'd0;
            starve       <= '0;
            tick_cnt     <= '0;
            tick_pending <= 1'b0;
            last_dir1    <= 2'd0;
            last_dir2    <= 2'd2;
            x1           <= 7'(START_X1);
            x2           <= 7'(START_X2);
            y1           <= 6'(START_Y);
            y2           <= 6'(START_Y);
            game_over    <= 1'b0;
            disp_valid   <= 1'b0;
            if (reset) begin
                score1 <= 10'd0;
                score2 <= 10'd0;
            end
        end else begin
            state      <= state_nxt;
            disp_valid <= disp_grant;

            if (access && disp_grant)
                starve <= starve + 1'b1;
            else
                starve <= '0;

            // Row/col counters track the linear sweep address so the wall test needs no divide
            if ((state == CLEAR) && sched_go) begin
                clr_addr <= clr_addr + 13'd1;
                if (int'(clr_col) == COLS - 1) begin
                    clr_col <= 7'd0;
                    clr_row <= clr_row + 6'd1;
                end else begin
                    clr_col <= clr_col + 7'd1;
                end
            end

            if ((state == WAIT_TICK) && tick_pending)
                tick_pending <= 1'b0;
            if (tick_run) begin
                if (tick_cnt == TICK_W'(TICK - 1)) begin
                    tick_cnt     <= '0;
                    tick_pending <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end

            if (state == CALC) begin
                last_dir1 <= eff_dir1;
                last_dir2 <= eff_dir2;
            end

            if (state == JUDGE) begin
                if (!c1 && !c2) begin
                    x1 <= nx1;
                    y1 <= ny1;
                    x2 <= nx2;
                    y2 <= ny2;
                end else begin
                    game_over <= 1'b1;
                    if (c1)
                        score2 <= sat_inc(score2);
                    if (c2)
                        score1 <= sat_inc(score1);
                end
            end
        end
    end

    // Move candidates and read-back cell contents carry no reset; they are rewritten every tick
    always_ff @(posedge CLOCK_50) begin
        if (state == CALC) begin
            nx1 <= step_col(x1, eff_dir1);
            ny1 <= step_row(y1, eff_dir1);
            nx2 <= step_col(x2, eff_dir2);
            ny2 <= step_row(y2, eff_dir2);
        end
        if (state == CAP1)
            d1 <= mem_rdata;
        if (state == CAP2)
            d2 <= mem_rdata;
    end

endmodule

// File: tb/tb_escalonador_rodada.sv
// Directed bench for escalonador_rodada: grid clear, moves, collisions, arbitration, round restart.
// The grid RAM is modelled here as a registered-read single-port array.
module tb_escalonador_rodada;

    logic        CLOCK_50 = 1'b0;
    logic        reset, reiniciar;
    logic [1:0]  dir1, dir2;
    logic        disp_req;
    logic [12:0] disp_addr;
    logic        disp_grant, disp_valid;
    logic [12:0] mem_addr;
    logic [1:0]  mem_wdata;
    logic        mem_we;
    logic [1:0]  mem_rdata = 2'd0;
    logic [6:0]  x1, x2;
    logic [5:0]  y1, y2;
    logic [9:0]  score1, score2;
    logic        game_over, busy;

    logic [1:0]  ram [0:8191];
    int          checks = 0;
    int          failures = 0;
    int          n, nwe, ng, pm, vm, am;
    logic        prev;

    escalonador_rodada #(.TICK(64)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .reiniciar (reiniciar),
        .dir1      (dir1),
        .dir2      (dir2),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_grant(disp_grant),
        .disp_valid(disp_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .x1        (x1),
        .y1        (y1),
        .x2        (x2),
        .y2        (y2),
        .score1    (score1),
        .score2    (score2),
        .game_over (game_over),
        .busy      (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_busy_low(input int bound);
        int k = 0;
        while (busy && k < bound) begin
            @(negedge CLOCK_50);
            k++;
        end
        check("busy_low_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_game_over(input int bound);
        int k = 0;
        while (!game_over && k < bound) begin
            @(negedge CLOCK_50);
            k++;
        end
        check("game_over_timeout", {31'd0, game_over}, 32'd1);
    endtask

    task automatic wait_x1_move(input logic [6:0] from, input int bound);
        int k = 0;
        while (x1 == from && k < bound) begin
            @(negedge CLOCK_50);
            k++;
        end
        check("x1_move_timeout", {31'd0, (x1 != from)}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++)
            ram[i] = 2'd1;
        reset     = 1'b1;
        reiniciar = 1'b0;
        dir1      = 2'd0;
        dir2      = 2'd2;
        disp_req  = 1'b0;
        disp_addr = 13'd0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);

        check("rst_busy",   {31'd0, busy}, 32'd1);
        check("rst_x1",     {25'd0, x1}, 32'd27);
        check("rst_y1",     {26'd0, y1}, 32'd30);
        check("rst_x2",     {25'd0, x2}, 32'd52);
        check("rst_y2",     {26'd0, y2}, 32'd30);
        check("rst_score1", {22'd0, score1}, 32'd0);
        check("rst_score2", {22'd0, score2}, 32'd0);
        check("rst_over",   {31'd0, game_over}, 32'd0);
        check("rst_dvalid", {31'd0, disp_valid}, 32'd0);

        // Uncontended clear sweep
        reset = 1'b0;
        n = 0;
        nwe = 0;
        while (busy && n < 30000) begin
            n++;
            if (mem_we)
                nwe++;
            @(negedge CLOCK_50);
        end
        check("clear_cycles", n, 32'd4800);
        check("clear_we",     nwe, 32'd4800);
        check("cell_0_0",     {30'd0, ram[0]}, 32'd3);
        check("cell_2_2",     {30'd0, ram[2*80+2]}, 32'd0);
        check("cell_77_57",   {30'd0, ram[57*80+77]}, 32'd0);
        check("cell_78_57",   {30'd0, ram[57*80+78]}, 32'd3);

        // First tick, then head-on draw at tick 13
        wait_x1_move(7'd27, 300);
        check("t1_cell_j1", {30'd0, ram[30*80+27]}, 32'd1);
        check("t1_cell_j2", {30'd0, ram[30*80+52]}, 32'd2);
        check("t1_x1",      {25'd0, x1}, 32'd28);
        check("t1_x2",      {25'd0, x2}, 32'd51);
        check("t1_over",    {31'd0, game_over}, 32'd0);
        wait_game_over(2000);
        check("draw_score1", {22'd0, score1}, 32'd1);
        check("draw_score2", {22'd0, score2}, 32'd1);
        check("draw_x1",     {25'd0, x1}, 32'd39);
        check("draw_x2",     {25'd0, x2}, 32'd40);

        // J1 up, J2 down: J2 reaches the bottom wall at tick 28
        reiniciar = 1'b1;
        dir1 = 2'd3;
        dir2 = 2'd1;
        @(negedge CLOCK_50);
        reiniciar = 1'b0;
        check("r2_busy",   {31'd0, busy}, 32'd1);
        check("r2_over",   {31'd0, game_over}, 32'd0);
        check("r2_score1", {22'd0, score1}, 32'd1);
        wait_busy_low(6000);
        wait_game_over(3000);
        check("wall_score1", {22'd0, score1}, 32'd2);
        check("wall_score2", {22'd0, score2}, 32'd1);
        check("wall_y2",     {26'd0, y2}, 32'd57);
        check("wall_y1",     {26'd0, y1}, 32'd3);
        check("wall_x1",     {25'd0, x1}, 32'd27);
        check("wall_x2",     {25'd0, x2}, 32'd52);

        // Another draw brings the scores to 3/2
        reiniciar = 1'b1;
        dir1 = 2'd0;
        dir2 = 2'd2;
        @(negedge CLOCK_50);
        reiniciar = 1'b0;
        wait_busy_low(6000);
        wait_game_over(2000);
        check("r3_score1", {22'd0, score1}, 32'd3);
        check("r3_score2", {22'd0, score2}, 32'd2);

        // Clear with the display requesting every cycle
        reiniciar = 1'b1;
        disp_req  = 1'b1;
        disp_addr = 13'd1234;
        @(negedge CLOCK_50);
        reiniciar = 1'b0;
        n = 0; ng = 0; nwe = 0; pm = 0; vm = 0; am = 0;
        while (busy && n < 30000) begin
            n++;
            if (disp_grant)
                ng++;
            if (mem_we)
                nwe++;
            if (disp_grant !== ((n % 5) != 0))
                pm++;
            if (disp_grant && mem_addr !== 13'd1234)
                am++;
            prev = disp_grant;
            @(negedge CLOCK_50);
            if (disp_valid !== prev)
                vm++;
        end
        disp_req = 1'b0;
        check("arb_cycles",      n, 32'd24000);
        check("arb_grants",      ng, 32'd19200);
        check("arb_writes",      nwe, 32'd4800);
        check("arb_pattern_err", pm, 32'd0);
        check("arb_valid_err",   vm, 32'd0);
        check("arb_addr_err",    am, 32'd0);
        check("arb_trail_gone",  {30'd0, ram[30*80+39]}, 32'd0);
        check("arb_wall",        {30'd0, ram[0]}, 32'd3);

        // Restart mid-round, then a reversal request on the first tick
        wait_x1_move(7'd27, 300);
        wait_x1_move(7'd28, 300);
        wait_x1_move(7'd29, 300);
        check("mid_x1", {25'd0, x1}, 32'd30);
        reiniciar = 1'b1;
        dir1 = 2'd2;
        @(negedge CLOCK_50);
        reiniciar = 1'b0;
        check("rr_busy",   {31'd0, busy}, 32'd1);
        check("rr_x1",     {25'd0, x1}, 32'd27);
        check("rr_x2",     {25'd0, x2}, 32'd52);
        check("rr_y1",     {26'd0, y1}, 32'd30);
        check("rr_y2",     {26'd0, y2}, 32'd30);
        check("rr_score1", {22'd0, score1}, 32'd3);
        check("rr_score2", {22'd0, score2}, 32'd2);
        wait_busy_low(6000);
        wait_x1_move(7'd27, 300);
        check("rev_x1", {25'd0, x1}, 32'd28);
        check("rev_x2", {25'd0, x2}, 32'd51);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/escalonador_rodada.md
Name: escalonador_rodada

Overview:
- Round scheduler and grid-RAM arbiter for the two-player light-cycle arena.
- Owns the single-port 80x60 grid RAM (2-bit cells: 0 free, 1 trail J1, 2 trail J2, 3 wall), the game tick, and player positions.
- Sequences each round: clear, then per tick mark / advance / read / judge.
- Shares the RAM port with the VGA read path through a bounded-starvation priority arbiter.

Parameters:
- COLS, 80, grid columns.
- ROWS, 60, grid rows.
- BORDER, 2, wall thickness in cells on every edge.
- TICK, 2500000, CLOCK_50 cycles per game step.
- START_X1, 27, J1 start column.
- START_X2, 52, J2 start column.
- START_Y, 30, start row for both players.
- STARVE_MAX, 4, maximum consecutive cycles the display may block a pending scheduler access.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous active-high; full reset including scores
- reiniciar  in  1  synchronous new round; scores kept
- dir1  in  2  J1 requested direction: 0 right, 1 down, 2 left, 3 up
- dir2  in  2  J2 requested direction, same encoding
- disp_req  in  1  display read request
- disp_addr  in  13  display cell address, row*COLS+col
- disp_grant  out  1  combinational; display owns the port this cycle
- disp_valid  out  1  registered; mem_rdata holds display data this cycle
- mem_addr  out  13  RAM address
- mem_wdata  out  2  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  2  RAM read data, valid 1 cycle after address
- x1, y1, x2, y2  out  7/6/7/6  current player cells
- score1, score2  out  10  win counters, saturating at 1023
- game_over  out  1  round ended
- busy  out  1  high while in CLEAR

Behaviour:
- Reset: state CLEAR, sweep counters 0, coordinates at start, last directions J1=0 and J2=2, tick counter 0, game_over=0, disp_valid=0, scores 0.
- reiniciar: same as reset except scores are held. Both signals act mid-operation, including mid-CLEAR, where the sweep restarts at address 0.
- States: CLEAR, WAIT_TICK, MARK1, MARK2, CALC, READ1, CAP1, READ2, CAP2, JUDGE, OVER.
- Access states are CLEAR, MARK1, MARK2, READ1 and READ2. These advance only in a cycle where the scheduler is granted. All other states advance every cycle.
- Arbitration: in an access state, the display is granted when disp_req=1 and starve<STARVE_MAX; starve then increments. Otherwise the scheduler is granted and starve resets to 0. Outside access states, disp_req is always granted. disp_valid is disp_grant delayed by 1 cycle.
- During a display grant: mem_addr=disp_addr and mem_we=0.
- CLEAR:
  - Writes one cell per grant, using row/col counters with no division.
  - Wall cells are row<BORDER, row>=ROWS-BORDER, col<BORDER or col>=COLS-BORDER; they get 3, all others 0.
  - After address 4799 is written, go to WAIT_TICK.
- Tick counter runs only in WAIT_TICK through JUDGE; it wraps at TICK-1 and sets tick_pending. WAIT_TICK leaves when tick_pending is set, and clears it.
- MARK1 writes 1 at (x1,y1); MARK2 writes 2 at (x2,y2).
- CALC:
  - Samples dir1 and dir2.
  - A requested direction opposite the last used direction (XOR 2) is ignored and the previous direction is kept.
  - Computes next cells as +/-1 on col or row.
- READ1 and READ2 read the J1 and J2 next cells. CAP1 and CAP2 latch mem_rdata into d1 and d2.
- JUDGE:
  - c1 = (d1!=0) or (next1==next2); c2 = (d2!=0) or (next1==next2).
  - No collision: commit next cells to x/y, go to WAIT_TICK.
  - Otherwise: if c1, score2++; if c2, score1++ (a draw increments both). Set game_over=1, go to OVER; coordinates are not committed.
- OVER holds until reset or reiniciar. The display is always granted in OVER.

Test Plan:
- reset, disp_req=0 -> busy high for exactly 4800 cycles with mem_we=1; address 0 gets 3, (2,2) gets 0, (77,57) gets 0, (78,57) gets 3; then WAIT_TICK.
- TICK=64, dir1=0, dir2=2, no display -> after first tick, cell (27,30)=1, cell (52,30)=2, x1=28, x2=51, game_over=0.
- dir1=3, dir2=1 held -> at tick 28, J2 next row 58 is wall: game_over=1, score1=1, score2=0, y2=57, y1=3.
- dir1=0, dir2=2 held -> at tick 13 with x1=39 and x2=40, both next cells are trails: score1=1, score2=1.
- disp_req held high during CLEAR, STARVE_MAX=4 -> pattern of 4 display grants then 1 scheduler write; CLEAR takes 24000 cycles; disp_valid trails disp_grant by 1 cycle.
- reiniciar pulsed mid-round with scores 3/2 -> busy reasserts, coordinates return to 27/52/30, scores stay 3/2; dir1=2 on the first tick is ignored as a reversal and x1=28.
